// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-vector bit positions and the
// write-back source select used by the WB stage.
package mips_pkg;

  localparam int CTL_W        = 11;
  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_LINK     = 2;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  // LINK outranks MEMTOREG so JAL/JALR always write the return address.
  function automatic wb_sel_t wb_select(input logic [CTL_W-1:0] ctl);
    if (ctl[CTL_LINK])          return WB_LINK;
    else if (ctl[CTL_MEMTOREG]) return WB_MEM;
    else                        return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_mux.sv
// Combinational 3:1 write-back data select steered by a wb_sel_t code.
module wb_mux
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  wb_sel_t         sel,
  input  logic [SIZE-1:0] alu,
  input  logic [SIZE-1:0] mem,
  input  logic [SIZE-1:0] link,
  output logic [SIZE-1:0] y
);

  always_comb begin
    y = alu;
    unique case (sel)
      WB_MEM:  y = mem;
      WB_LINK: y = link;
      default: y = alu;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: stage register, one-deep write history for ID bypass
// and an optional retired-instruction counter (enabled by WB_RETIRE_CNT_EN).
module wb_stage
  import mips_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int AW       = $clog2(SIZE),
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_mem,
  input  logic [CTL_W-1:0]    control_mem,
  input  logic [SIZE-1:0]     ALUresult_MEM,
  input  logic [SIZE-1:0]     mem_rdata,
  input  logic [SIZE-1:0]     PC_4_MEM,
  input  logic [AW-1:0]       writeReg_MEM,
  output logic                reg_we,
  output logic [AW-1:0]       reg_waddr,
  output logic [SIZE-1:0]     reg_wdata,
  output logic                written,
  output logic                prev_we,
  output logic [AW-1:0]       prev_waddr,
  output logic [SIZE-1:0]     prev_wdata,
  output logic [RETIRE_W-1:0] retire_count
);

  logic            commit;
  logic [SIZE-1:0] wdata_sel;
  logic            unused_ctl;

  assign commit     = valid_mem & control_mem[CTL_REGWRITE] & (writeReg_MEM != '0);
  assign unused_ctl = ^control_mem[CTL_W-1:CTL_LINK+1];

  wb_mux #(.SIZE(SIZE)) u_mux (
    .sel  (wb_select(control_mem)),
    .alu  (ALUresult_MEM),
    .mem  (mem_rdata),
    .link (PC_4_MEM),
    .y    (wdata_sel)
  );

  // Stage and history ranks shift together; written is the same flop as reg_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we     <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
      prev_we    <= 1'b0;
      prev_waddr <= '0;
      prev_wdata <= '0;
    end else begin
      reg_we     <= commit;
      reg_waddr  <= writeReg_MEM;
      reg_wdata  <= wdata_sel;
      prev_we    <= reg_we;
      prev_waddr <= reg_waddr;
      prev_wdata <= reg_wdata;
    end
  end

  assign written = reg_we;

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_q;

  // Suppressed $zero writes still retire; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retire_q <= '0;
    else if (valid_mem) retire_q <= retire_q + 1'b1;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage; retire counter checks follow WB_RETIRE_CNT_EN.
module tb_wb_stage;

  localparam int SIZE     = 32;
  localparam int AW       = 5;
  localparam int RETIRE_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid_mem;
  logic [10:0]         control_mem;
  logic [SIZE-1:0]     ALUresult_MEM;
  logic [SIZE-1:0]     mem_rdata;
  logic [SIZE-1:0]     PC_4_MEM;
  logic [AW-1:0]       writeReg_MEM;
  logic                reg_we;
  logic [AW-1:0]       reg_waddr;
  logic [SIZE-1:0]     reg_wdata;
  logic                written;
  logic                prev_we;
  logic [AW-1:0]       prev_waddr;
  logic [SIZE-1:0]     prev_wdata;
  logic [RETIRE_W-1:0] retire_count;

  typedef struct {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [SIZE-1:0] wdata;
  } exp_t;

  exp_t                sb[$];
  exp_t                prev_model;
  logic [RETIRE_W-1:0] cnt_model;
  int                  checks = 0;
  int                  fails  = 0;

  wb_stage #(.SIZE(SIZE), .AW(AW), .RETIRE_W(RETIRE_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_mem     (valid_mem),
    .control_mem   (control_mem),
    .ALUresult_MEM (ALUresult_MEM),
    .mem_rdata     (mem_rdata),
    .PC_4_MEM      (PC_4_MEM),
    .writeReg_MEM  (writeReg_MEM),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .written       (written),
    .prev_we       (prev_we),
    .prev_waddr    (prev_waddr),
    .prev_wdata    (prev_wdata),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RETIRE_W-1:0] exp_count();
`ifdef WB_RETIRE_CNT_EN
    return cnt_model;
`else
    return '0;
`endif
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check("reg_we",     reg_we,     e.we);
    check("written",    written,    e.we);
    check("reg_waddr",  reg_waddr,  e.waddr);
    check("reg_wdata",  reg_wdata,  e.wdata);
    check("prev_we",    prev_we,    prev_model.we);
    check("prev_waddr", prev_waddr, prev_model.waddr);
    check("prev_wdata", prev_wdata, prev_model.wdata);
    check("retire",     retire_count, exp_count());
    prev_model = e;
  endtask

  task automatic applyStimulus(input logic v, input logic [10:0] ctl, input logic [31:0] alu,
                               input logic [31:0] md, input logic [31:0] pc, input logic [4:0] rg);
    exp_t e;
    valid_mem     = v;
    control_mem   = ctl;
    ALUresult_MEM = alu;
    mem_rdata     = md;
    PC_4_MEM      = pc;
    writeReg_MEM  = rg;
    e.we    = v & ctl[0] & (rg != 5'd0);
    e.waddr = rg;
    e.wdata = ctl[2] ? pc : (ctl[1] ? md : alu);
    sb.push_back(e);
    if (v) cnt_model = cnt_model + 1'b1;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_we"},     reg_we,       0);
    check({tag, "_wr"},     written,      0);
    check({tag, "_waddr"},  reg_waddr,    0);
    check({tag, "_wdata"},  reg_wdata,    0);
    check({tag, "_pwe"},    prev_we,      0);
    check({tag, "_pwaddr"}, prev_waddr,   0);
    check({tag, "_pwdata"}, prev_wdata,   0);
    check({tag, "_cnt"},    retire_count, 0);
  endtask

  task automatic resetModel();
    sb.delete();
    prev_model = '{we: 1'b0, waddr: '0, wdata: '0};
    cnt_model  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_mem = 1'b0; control_mem = '0; ALUresult_MEM = '0;
    mem_rdata = '0; PC_4_MEM = '0; writeReg_MEM = '0;
    resetModel();
    #2;
    checkAllZero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);

    // R-type, then a bubble confirms written lasts one cycle
    applyStimulus(1, 11'h001, 32'h7, 32'h0, 32'h0, 5'd8);
    applyStimulus(0, 11'h000, 32'h0, 32'h0, 32'h0, 5'd0);
    // Load; prev_* shows it on the following step
    applyStimulus(1, 11'h003, 32'h40, 32'hDEADBEEF, 32'h0, 5'd9);
    applyStimulus(1, 11'h005, 32'h40, 32'h0, 32'h104, 5'd31);
    // $zero write then bubble
    applyStimulus(1, 11'h001, 32'h55, 32'h0, 32'h0, 5'd0);
    applyStimulus(0, 11'h001, 32'h66, 32'h0, 32'h0, 5'd3);
    // Back-to-back to the same register, ignored upper control bits
    applyStimulus(1, 11'h7F9, 32'h11, 32'h22, 32'h33, 5'd4);
    applyStimulus(1, 11'h003, 32'h11, 32'h22, 32'h33, 5'd4);
    applyStimulus(1, 11'h000, 32'hAA, 32'hBB, 32'hCC, 5'd5);

    // Reset mid-stream while reg_we is high
    applyStimulus(1, 11'h001, 32'h99, 32'h0, 32'h0, 5'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    resetModel();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cnt", retire_count, 0);

    // 17 valid instructions wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 11'h001, i, 32'h0, 32'h0, 5'(i % 32));
`ifdef WB_RETIRE_CNT_EN
    check("wrap17", retire_count, 1);
`else
    check("wrap17", retire_count, 0);
`endif
    applyStimulus(0, 11'h000, 32'h0, 32'h0, 32'h0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
